wb_write_buffer: RTL and testbench

Writeback-side write buffer that sits directly upstream of the 16-entry register file and drives its single write port. It accepts register writes from the writeback stage through a valid/ready handshake and queues up to DEPTH of them. It retires one write per cycle as one-hot WriteReg enables plus shared D data, whenever the pipeline grants the write port. Its two read ports take the register file's bitline read data and return the youngest matching queued value in its place, so reads always see the architecturally newest data.

---
 rtl/wb_write_buffer.sv | 96 +++++++++
 tb/tb_wb_write_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_buffer.sv
// Register-file write buffer: queues writeback writes and retires them one per granted cycle.
// Retire is visible the cycle after accept; wb_ready drops only when full (no accept-while-draining on full).
module wb_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [$clog2(NREG)-1:0] wb_reg,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    drain_en,
  output logic [NREG-1:0]         wr_en,
  output logic [DATA_W-1:0]       wr_data,
  input  logic [$clog2(NREG)-1:0] rd_addr1,
  input  logic [$clog2(NREG)-1:0] rd_addr2,
  input  logic [DATA_W-1:0]       rf_data1,
  input  logic [DATA_W-1:0]       rf_data2,
  output logic [DATA_W-1:0]       rd_data1,
  output logic [DATA_W-1:0]       rd_data2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic                    empty,
  output logic                    full
);
  localparam int RW = $clog2(NREG);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [RW-1:0]     rg;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          accept;
  logic          drain;

  // Status is forced to the reset view while rst is high so nothing retires in the reset cycle.
  assign wb_ready = !rst && (count < (PW+1)'(DEPTH));
  assign empty    = rst || (count == '0);
  assign full     = !rst && (count == (PW+1)'(DEPTH));
  assign accept   = wb_valid && wb_ready;
  assign drain    = drain_en && !empty;

  assign wr_en   = drain ? (NREG'(1) << mem[head].rg) : '0;
  assign wr_data = drain ? mem[head].dat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= '{rg: wb_reg, dat: wb_data};
  end

  // Walk oldest to youngest so the last match wins; the head entry still counts while draining.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    byp_hit1 = 1'b0;
    byp_hit2 = 1'b0;
    rd_data1 = rf_data1;
    rd_data2 = rf_data2;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!rst && ((PW+1)'(i) < count)) begin
        if (mem[idx].rg == rd_addr1) begin
          byp_hit1 = 1'b1;
          rd_data1 = mem[idx].dat;
        end
        if (mem[idx].rg == rd_addr2) begin
          byp_hit2 = 1'b1;
          rd_data2 = mem[idx].dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Randomized and directed bench for wb_write_buffer against a queue-based reference model.
module tb_wb_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        drain_en;
  logic [15:0] wr_en;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rf_data1, rf_data2;
  logic [15:0] rd_data1, rd_data2;
  logic        byp_hit1, byp_hit2;
  logic        empty, full;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  rg;
    logic [15:0] dat;
  } ent_t;
  ent_t mq[$];

  wb_write_buffer #(.DEPTH(DEPTH), .DATA_W(16), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .drain_en(drain_en), .wr_en(wr_en), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: youngest queued write to a register wins, else the register file value.
  function automatic logic m_hit(input logic [3:0] a);
    if (rst) return 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rg == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_rd(input logic [3:0] a, input logic [15:0] rf);
    if (rst) return rf;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rg == a) return mq[i].dat;
    return rf;
  endfunction

  function automatic logic m_drain();
    return drain_en && !rst && (mq.size() > 0);
  endfunction

  function automatic logic [15:0] m_wr_en();
    logic [15:0] one;
    one = 16'd1;
    return m_drain() ? (one << mq[0].rg) : 16'd0;
  endfunction

  function automatic logic [15:0] m_wr_data();
    return m_drain() ? mq[0].dat : 16'd0;
  endfunction

  // Advance one clock, applying the current inputs to the model; inputs settle #1 after the edge.
  task automatic drive_edge();
    logic acc, drn;
    acc = wb_valid && !rst && (mq.size() < DEPTH);
    drn = m_drain();
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{rg: wb_reg, dat: wb_data});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_valid = 0; drain_en = 0; wb_reg = 0; wb_data = 0;
    rd_addr1 = 0; rd_addr2 = 0; rf_data1 = 16'h1111; rf_data2 = 16'h2222;
    drive_edge(); drive_edge();
    n_cmp++; if (wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", wb_ready); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL reset_wr_en got %h exp 0", wr_en); end
    n_cmp++; if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b%b exp 00", byp_hit1, byp_hit2); end
    rst = 1'b0;
    drive_edge();
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", wb_ready); end
  endtask

  task automatic test_single();
    wb_valid = 1; wb_reg = 4'd3; wb_data = 16'h1234; drain_en = 0;
    drive_edge();
    wb_valid = 0; drain_en = 1;
    #1;
    n_cmp++; if (wr_en !== 16'h0008) begin n_fail++; $display("FAIL single_wr_en got %h exp 0008", wr_en); end
    n_cmp++; if (wr_data !== 16'h1234) begin n_fail++; $display("FAIL single_wr_data got %h exp 1234", wr_data); end
    drive_edge();
    drain_en = 0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b exp 1", empty); end
  endtask

  task automatic test_fill();
    logic [15:0] sent[$];
    drain_en = 0;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1; wb_reg = 4'(i + 8); wb_data = 16'($urandom);
      sent.push_back(wb_data);
      drive_edge();
    end
    n_cmp++; if (full !== 1'b1 || wb_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%b rdy=%b exp 1/0", full, wb_ready); end
    wb_reg = 4'd1; wb_data = 16'hDEAD;
    drive_edge();
    wb_valid = 0;
    // Full queue must not accept even while draining.
    wb_valid = 1; drain_en = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (wr_data !== sent[i]) begin n_fail++; $display("FAIL fill_order[%0d] got %h exp %h", i, wr_data, sent[i]); end
      if (i == 0) wb_valid = 0;
      drive_edge();
    end
    drain_en = 0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained_empty got %b exp 1 (size %0d)", empty, mq.size()); end
  endtask

  task automatic test_bypass();
    drain_en = 0; wb_valid = 1; wb_reg = 4'd5; wb_data = 16'h00AA;
    drive_edge();
    wb_data = 16'h00BB;
    drive_edge();
    wb_valid = 0; rd_addr1 = 4'd5; rf_data1 = 16'hFFFF; rd_addr2 = 4'd6; rf_data2 = 16'h1357;
    #1;
    n_cmp++; if (rd_data1 !== 16'h00BB || byp_hit1 !== 1'b1) begin n_fail++; $display("FAIL byp_youngest got %h/%b exp 00bb/1", rd_data1, byp_hit1); end
    n_cmp++; if (rd_data2 !== 16'h1357 || byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL byp_miss got %h/%b exp 1357/0", rd_data2, byp_hit2); end
    drain_en = 1;
    while (mq.size() > 0) drive_edge();
    drain_en = 0;
  endtask

  task automatic test_same_cycle();
    wb_valid = 1; wb_reg = 4'd2; wb_data = 16'h0042; rd_addr1 = 4'd2; rf_data1 = 16'h7777; drain_en = 0;
    #1;
    n_cmp++; if (byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL same_cycle_hit got %b exp 0", byp_hit1); end
    drive_edge();
    wb_valid = 0;
    #1;
    n_cmp++; if (byp_hit1 !== 1'b1 || rd_data1 !== 16'h0042) begin n_fail++; $display("FAIL next_cycle_hit got %b/%h exp 1/0042", byp_hit1, rd_data1); end
    drain_en = 1;
    drive_edge();
    drain_en = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] sent[$];
    drain_en = 0; wb_valid = 1;
    for (int i = 0; i < 2; i++) begin
      wb_reg = 4'($urandom); wb_data = 16'($urandom); sent.push_back(wb_data);
      drive_edge();
    end
    drain_en = 1;
    for (int i = 0; i < 10; i++) begin
      wb_reg = 4'($urandom); wb_data = 16'($urandom); sent.push_back(wb_data);
      #1;
      n_cmp++; if (wr_data !== sent[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", i, wr_data, sent[i]); end
      n_cmp++; if (empty !== 1'b0 || full !== 1'b0 || wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_status[%0d] got e=%b f=%b r=%b exp 0/0/1", i, empty, full, wb_ready); end
      drive_edge();
    end
    wb_valid = 0;
    for (int i = 10; i < 12; i++) begin
      #1;
      n_cmp++; if (wr_data !== sent[i]) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, wr_data, sent[i]); end
      drive_edge();
    end
    drain_en = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wb_valid = $urandom_range(0, 2) != 0;
      drain_en = $urandom_range(0, 2) == 0;
      wb_reg   = 4'($urandom_range(0, 5));
      wb_data  = 16'($urandom);
      rd_addr1 = 4'($urandom_range(0, 5));
      rd_addr2 = 4'($urandom_range(0, 5));
      rf_data1 = 16'($urandom);
      rf_data2 = 16'($urandom);
      #1;
      n_cmp++; if (wr_en !== m_wr_en() || wr_data !== m_wr_data()) begin n_fail++; $display("FAIL rnd_write[%0d] got %h/%h exp %h/%h", c, wr_en, wr_data, m_wr_en(), m_wr_data()); end
      n_cmp++; if (wb_ready !== (!rst && mq.size() < DEPTH) || empty !== (rst || mq.size() == 0) || full !== (!rst && mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_status[%0d] got r=%b e=%b f=%b size %0d", c, wb_ready, empty, full, mq.size()); end
      n_cmp++; if (byp_hit1 !== m_hit(rd_addr1) || rd_data1 !== m_rd(rd_addr1, rf_data1)) begin n_fail++; $display("FAIL rnd_port1[%0d] got %b/%h exp %b/%h", c, byp_hit1, rd_data1, m_hit(rd_addr1), m_rd(rd_addr1, rf_data1)); end
      n_cmp++; if (byp_hit2 !== m_hit(rd_addr2) || rd_data2 !== m_rd(rd_addr2, rf_data2)) begin n_fail++; $display("FAIL rnd_port2[%0d] got %b/%h exp %b/%h", c, byp_hit2, rd_data2, m_hit(rd_addr2), m_rd(rd_addr2, rf_data2)); end
      drive_edge();
    end
    rst = 0; wb_valid = 0; drain_en = 1;
    while (mq.size() > 0) drive_edge();
    drain_en = 0;
  endtask

  task automatic test_reset_mid();
    drain_en = 0; wb_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wb_reg = 4'(i + 1); wb_data = 16'(16'h0100 + i);
      drive_edge();
    end
    wb_valid = 0; drain_en = 1; rst = 1;
    #1;
    n_cmp++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL rstmid_cycle_wr_en got %h exp 0", wr_en); end
    drive_edge();
    rst = 0;
    #1;
    n_cmp++; if (empty !== 1'b1 || wr_en !== 16'h0) begin n_fail++; $display("FAIL rstmid_after got e=%b wr_en=%h exp 1/0", empty, wr_en); end
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      #1;
      n_cmp++; if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_miss[%0d] got %b%b exp 00", a, byp_hit1, byp_hit2); end
    end
    drive_edge();
    n_cmp++; if (wr_en !== 16'h0) begin n_fail++; $display("FAIL rstmid_later_wr_en got %h exp 0", wr_en); end
    drain_en = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_bypass();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
